muldiv_unit: RTL and testbench

Iterative multi-cycle multiply/divide unit that sits beside the single-cycle ALU in the MIPS execute stage. It executes MULT, MULTU, DIV and DIVU into the architectural HI/LO register pair, and performs MTHI/MTLO writes. The pipeline controller issues work to it with a start/busy/done handshake and reads `hi`/`lo` directly for MFHI/MFLO.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/adder_32.sv | 17 +
 rtl/muldiv_unit.sv | 200 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit:
// op codes, FSM state encoding, iteration count and a small
// conditional-negate helper used for magnitudes and sign fix-up.
package muldiv_pkg;

   localparam int MD_ITER = 32;

   localparam logic [2:0] MD_MULT  = 3'b000;
   localparam logic [2:0] MD_MULTU = 3'b001;
   localparam logic [2:0] MD_DIV   = 3'b010;
   localparam logic [2:0] MD_DIVU  = 3'b011;
   localparam logic [2:0] MD_MTHI  = 3'b100;
   localparam logic [2:0] MD_MTLO  = 3'b101;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_MUL  = 3'd1;
   localparam logic [2:0] S_DIV  = 3'd2;
   localparam logic [2:0] S_FIX  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   function automatic logic [31:0] md_cond_neg(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/adder_32.sv
// 32-bit ripple adder with carry in/out, shared by the multiply
// partial-sum and the division trial subtract.
//   a, b      : addends
//   carryin   : carry into bit 0
//   sum       : 32-bit result
//   carryout  : carry out of bit 31
module adder_32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        carryin,
   output logic [31:0] sum,
   output logic        carryout
);

   assign {carryout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, carryin};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the execute stage. Runs
// MULT/MULTU/DIV/DIVU into HI/LO over 32 iterations plus a sign
// fix-up cycle, and performs single-edge MTHI/MTLO writes.
//   clk, rst         : clock, synchronous active-high reset
//   start, op        : request and op code (accepted when not busy)
//   in0, in1         : rs / rt operands
//   busy             : operation in flight
//   done             : one-cycle completion pulse
//   div_by_zero      : qualifies done for a divide by zero
//   hi, lo           : architectural HI/LO
//
// state  | meaning
// IDLE   | waiting for start
// MUL    | shift-add iteration, one multiplier bit per cycle
// DIV    | restoring-division iteration, one quotient bit per cycle
// FIX    | apply signs, write hi/lo
// DONE   | done pulse; a new start is accepted here too
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [2:0]  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   // MUL: {partial product high, multiplier shifting out}
   // DIV: {remainder, dividend shifting out / quotient shifting in}
   logic [63:0] acc_q, acc_d;
   logic [31:0] opnd_q, opnd_d;
   logic        sgn_q, sgn_d;
   logic        rsgn_q, rsgn_d;
   logic        isdiv_q, isdiv_d;
   logic        dz_q, dz_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic [31:0] add_a, add_b, add_sum;
   logic        add_cin, add_co;
   logic [32:0] part_rem;
   logic        div_ge;
   logic        signed_op;
   logic        s0, s1;
   logic [63:0] prod_fix;

   adder_32 u_adder (
      .a        (add_a),
      .b        (add_b),
      .carryin  (add_cin),
      .sum      (add_sum),
      .carryout (add_co)
   );

   // Remainder shifted left with the next dividend bit appended.
   assign part_rem = acc_q[63:31];
   // Low 32 bits carry out, or a set bit 32, means part_rem >= divisor.
   assign div_ge   = part_rem[32] | add_co;
   assign prod_fix = sgn_q ? (~acc_q + 64'd1) : acc_q;

   always_comb begin
      if (state_q == S_DIV) begin
         add_a   = part_rem[31:0];
         add_b   = ~opnd_q;
         add_cin = 1'b1;
      end else begin
         add_a   = acc_q[63:32];
         add_b   = acc_q[0] ? opnd_q : 32'd0;
         add_cin = 1'b0;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      sgn_d     = sgn_q;
      rsgn_d    = rsgn_q;
      isdiv_d   = isdiv_q;
      dz_d      = dz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      signed_op = (op == MD_MULT) || (op == MD_DIV);
      s0        = signed_op & in0[31];
      s1        = signed_op & in1[31];
      case (state_q)
         S_IDLE, S_DONE: begin
            if (state_q == S_DONE) begin
               state_d = S_IDLE;
               dz_d    = 1'b0;
            end
            if (start) begin
               case (op)
                  MD_MULT, MD_MULTU: begin
                     acc_d   = {32'd0, md_cond_neg(in1, s1)};
                     opnd_d  = md_cond_neg(in0, s0);
                     sgn_d   = s0 ^ s1;
                     rsgn_d  = s0;
                     isdiv_d = 1'b0;
                     cnt_d   = 5'd0;
                     dz_d    = 1'b0;
                     state_d = S_MUL;
                  end
                  MD_DIV, MD_DIVU: begin
                     if (in1 == 32'd0) begin
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                     end else begin
                        acc_d   = {32'd0, md_cond_neg(in0, s0)};
                        opnd_d  = md_cond_neg(in1, s1);
                        sgn_d   = s0 ^ s1;
                        rsgn_d  = s0;
                        isdiv_d = 1'b1;
                        cnt_d   = 5'd0;
                        dz_d    = 1'b0;
                        state_d = S_DIV;
                     end
                  end
                  MD_MTHI: begin
                     hi_d    = in0;
                     dz_d    = 1'b0;
                     state_d = S_DONE;
                  end
                  MD_MTLO: begin
                     lo_d    = in0;
                     dz_d    = 1'b0;
                     state_d = S_DONE;
                  end
                  default: ;
               endcase
            end
         end
         S_MUL: begin
            acc_d = {add_co, add_sum, acc_q[31:1]};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(MD_ITER - 1)) state_d = S_FIX;
         end
         S_DIV: begin
            acc_d = {(div_ge ? add_sum : part_rem[31:0]), acc_q[30:0], div_ge};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(MD_ITER - 1)) state_d = S_FIX;
         end
         S_FIX: begin
            if (isdiv_q) begin
               lo_d = md_cond_neg(acc_q[31:0], sgn_q);
               hi_d = md_cond_neg(acc_q[63:32], rsgn_q);
            end else begin
               hi_d = prod_fix[63:32];
               lo_d = prod_fix[31:0];
            end
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 5'd0;
         acc_q   <= 64'd0;
         opnd_q  <= 32'd0;
         sgn_q   <= 1'b0;
         rsgn_q  <= 1'b0;
         isdiv_q <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         sgn_q   <= sgn_d;
         rsgn_q  <= rsgn_d;
         isdiv_q <= isdiv_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy        = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
   assign done        = (state_q == S_DONE);
   assign div_by_zero = (state_q == S_DONE) && dz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] in0, in1;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .in0         (in0),
      .in1         (in1),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   // Called at posedge+1; drives start for one edge (E0) and returns at E0+1.
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; op = o; in0 = a; in1 = b;
      @(posedge clk); #1;
      start = 1'b0; in0 = 32'hDEADBEEF; in1 = 32'h0BADF00D;
   endtask

   // Edge count from E0 (inclusive) until done is seen, bounded.
   task automatic wait_done(output int edges);
      edges = 1;
      while (!done && edges < 100) begin
         @(posedge clk); #1;
         edges++;
      end
   endtask

   task automatic run_arith(input string name, input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      logic [31:0] old_hi, old_lo;
      old_hi = hi; old_lo = lo;
      issue(o, a, b);
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL %s busy_after_accept got=%b exp=1", name, busy);
      end
      repeat (10) @(posedge clk); #1;
      checks++;
      if (hi !== old_hi || lo !== old_lo) begin
         errors++; $display("FAIL %s hilo_stable got=%h_%h exp=%h_%h", name, hi, lo, old_hi, old_lo);
      end
      wait_done(n);
      n = n + 10;
      checks++;
      if (n != 34) begin
         errors++; $display("FAIL %s latency got=%0d exp=34", name, n);
      end
      checks++;
      if (hi !== exp_hi || lo !== exp_lo || div_by_zero !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s result got hi=%h lo=%h dz=%b busy=%b exp hi=%h lo=%h dz=0 busy=0",
                  name, hi, lo, div_by_zero, busy, exp_hi, exp_lo);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; op = 3'd0; in0 = 32'd0; in1 = 32'd0;
      repeat (3) @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (hi !== 32'd0 || lo !== 32'd0) begin
         errors++; $display("FAIL reset_hilo got=%h_%h exp=0_0", hi, lo);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
         errors++; $display("FAIL reset_flags got busy=%b done=%b dz=%b exp 0 0 0", busy, done, div_by_zero);
      end
   endtask

   task automatic test_mult();
      run_arith("mult_neg1x2",  3'b000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE);
      run_arith("multu_ffx2",   3'b001, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE);
      run_arith("mult_min_min", 3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
   endtask

   task automatic test_div();
      run_arith("div_m7_2",     3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_arith("divu_7_2",     3'b011, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003);
      run_arith("div_7_m2",     3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
      run_arith("div_overflow", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
      run_arith("divu_big",     3'b011, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF);
   endtask

   task automatic test_div_zero();
      issue(3'b100, 32'h11, 32'h0);
      checks++;
      if (hi !== 32'h11 || done !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL mthi got hi=%h done=%b busy=%b exp hi=11 done=1 busy=0", hi, done, busy);
      end
      issue(3'b101, 32'h22, 32'h0);
      checks++;
      if (lo !== 32'h22 || done !== 1'b1) begin
         errors++; $display("FAIL mtlo got lo=%h done=%b exp lo=22 done=1", lo, done);
      end
      @(posedge clk); #1;
      issue(3'b011, 32'h5, 32'h0);
      checks++;
      if (done !== 1'b1 || div_by_zero !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL divzero_flags got done=%b dz=%b busy=%b exp 1 1 0", done, div_by_zero, busy);
      end
      checks++;
      if (hi !== 32'h11 || lo !== 32'h22) begin
         errors++; $display("FAIL divzero_hilo got=%h_%h exp=11_22", hi, lo);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || div_by_zero !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL divzero_after got done=%b dz=%b busy=%b exp 0 0 0", done, div_by_zero, busy);
      end
   endtask

   task automatic test_reserved();
      issue(3'b110, 32'h1234, 32'h5);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin
         errors++; $display("FAIL reserved got done=%b busy=%b hi=%h lo=%h exp 0 0 11 22", done, busy, hi, lo);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL reserved_next got done=%b exp=0", done);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      issue(3'b000, 32'd3, 32'd4);
      repeat (4) @(posedge clk); #1;
      issue(3'b100, 32'h0000DEAD, 32'd0);
      wait_done(n);
      checks++;
      if (hi !== 32'd0 || lo !== 32'd12) begin
         errors++; $display("FAIL ignored_start got hi=%h lo=%h exp hi=0 lo=c", hi, lo);
      end
      issue(3'b101, 32'h0000ABCD, 32'd0);
      checks++;
      if (lo !== 32'h0000ABCD || hi !== 32'd0 || done !== 1'b1) begin
         errors++; $display("FAIL mtlo_in_done got lo=%h hi=%h done=%b exp lo=abcd hi=0 done=1", lo, hi, done);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int seen;
      issue(3'b001, 32'h12345678, 32'h9ABCDEF0);
      repeat (9) @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0) begin
         errors++; $display("FAIL reset_mid got busy=%b hi=%h lo=%h done=%b exp 0 0 0 0", busy, hi, lo, done);
      end
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL reset_mid_no_done got=%0d active cycles exp=0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_zero();
      test_reserved();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
